// File: rtl/aes256_key_sched_seq_pkg.sv
// Shared AES-256 key-schedule definitions: FSM states, round-key count,
// S-box table and Rcon helper used by the controller and the SubWord pipe.
package aes256_key_sched_seq_pkg;

    localparam int AES256_NUM_RK = 15;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EMIT = 2'd1,
        ST_SUB  = 2'd2
    } state_e;

    // Byte b lives at bits [8*(255-b) +: 8], i.e. byte 0 is the leftmost.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TABLE[{~b, 3'b000} +: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    // Valid for i = 1..7, the only indices an AES-256 schedule needs.
    function automatic logic [7:0] rcon(input logic [2:0] i);
        return 8'h01 << (i - 3'd1);
    endfunction

endpackage

// File: rtl/aes256_key_sched_seq_if.sv
// Key-in / round-key-out handshake bundle between the key scheduler and
// the cipher datapath.
interface aes256_key_sched_seq_if;

    logic         KEY_VALID;
    logic         KEY_READY;
    logic [0:255] KEY;
    logic         RK_VALID;
    logic         RK_READY;
    logic [0:127] RK;
    logic [3:0]   RK_IDX;
    logic         BUSY;
    logic         DONE;

    modport master (
        output KEY_VALID, KEY, RK_READY,
        input  KEY_READY, RK_VALID, RK, RK_IDX, BUSY, DONE
    );

    modport slave (
        input  KEY_VALID, KEY, RK_READY,
        output KEY_READY, RK_VALID, RK, RK_IDX, BUSY, DONE
    );

endinterface

// File: rtl/aes_sub_word_pipe.sv
// SubWord S-box with SBOX_LAT registered stages; the input is substituted
// on the first stage and simply shifted through the rest.
module aes_sub_word_pipe
    import aes256_key_sched_seq_pkg::*;
#(
    parameter int SBOX_LAT = 1
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [31:0] word_i,
    output logic [31:0] word_o
);

    logic [31:0] stage_q [SBOX_LAT];

    // NOTE: sequential state uses non-blocking assignments so every stage
    // samples the previous stage's old value on the same edge.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < SBOX_LAT; i++) stage_q[i] <= '0;
        end else begin
            stage_q[0] <= sub_word(word_i);
            for (int i = 1; i < SBOX_LAT; i++) stage_q[i] <= stage_q[i-1];
        end
    end

    assign word_o = stage_q[SBOX_LAT-1];

endmodule

// File: rtl/aes256_key_sched_seq.sv
// Sequential AES-256 key expansion: accepts one 256-bit key and streams
// RK0..RK14 over a valid/ready port, one expansion step per round key.
module aes256_key_sched_seq
    import aes256_key_sched_seq_pkg::*;
#(
    parameter int SBOX_LAT = 1,
    parameter int NUM_RK   = AES256_NUM_RK
) (
    input  logic                         CLK,
    input  logic                         RST_N,
    aes256_key_sched_seq_if.slave        bus
);

    localparam logic [3:0] LAST_IDX = 4'(NUM_RK - 1);
    localparam logic [1:0] LAT_C    = 2'(SBOX_LAT);

    state_e       state_q, state_d;
    logic [0:255] w_q, w_d;
    logic [0:127] rk_q, rk_d;
    logic [3:0]   idx_q, idx_d;
    logic         rk_valid_q, rk_valid_d;
    logic         done_q, done_d;
    logic [1:0]   cnt_q, cnt_d;

    logic         key_fire, rk_fire, step_even;
    logic [3:0]   idx_next;
    logic [31:0]  sub_in, sub_out;
    logic [31:0]  nk0, nk1, nk2, nk3;
    logic [0:127] nk;

    assign key_fire = bus.KEY_VALID && (state_q == ST_IDLE);
    assign rk_fire  = rk_valid_q && bus.RK_READY;

    // The window W only changes on SUB exit, so the S-box input stays
    // stable for the whole SUB phase without an extra capture register.
    assign idx_next  = idx_q + 4'd1;
    assign step_even = ~idx_next[0];
    assign sub_in    = step_even ? {w_q[232:255], w_q[224:231]} : w_q[224:255];

    aes_sub_word_pipe #(.SBOX_LAT(SBOX_LAT)) u_sub (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .word_i (sub_in),
        .word_o (sub_out)
    );

    assign nk0 = sub_out ^ (step_even ? {rcon(idx_next[3:1]), 24'h0} : 32'h0) ^ w_q[0:31];
    assign nk1 = nk0 ^ w_q[32:63];
    assign nk2 = nk1 ^ w_q[64:95];
    assign nk3 = nk2 ^ w_q[96:127];
    assign nk  = {nk0, nk1, nk2, nk3};

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // NOTE: every always_comb output gets a default first, so no path
    // through the case leaves a signal unassigned and infers a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (key_fire) state_d = ST_EMIT;
            ST_EMIT: begin
                if (rk_fire) begin
                    if (idx_q == LAST_IDX)  state_d = ST_IDLE;
                    else if (idx_q != 4'd0) state_d = ST_SUB;
                end
            end
            ST_SUB:  if (cnt_q == 2'd0) state_d = ST_EMIT;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.KEY_READY = (state_q == ST_IDLE);
        bus.BUSY      = (state_q != ST_IDLE);
    end

    // RK0 and RK1 are the key halves, so only RK2 onward pays the S-box wait.
    always_comb begin
        w_d        = w_q;
        rk_d       = rk_q;
        idx_d      = idx_q;
        rk_valid_d = rk_valid_q;
        done_d     = 1'b0;
        cnt_d      = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (key_fire) begin
                    w_d        = bus.KEY;
                    rk_d       = bus.KEY[0:127];
                    idx_d      = 4'd0;
                    rk_valid_d = 1'b1;
                end
            end
            ST_EMIT: begin
                if (rk_fire) begin
                    if (idx_q == LAST_IDX) begin
                        rk_valid_d = 1'b0;
                        done_d     = 1'b1;
                    end else if (idx_q == 4'd0) begin
                        rk_d  = w_q[128:255];
                        idx_d = 4'd1;
                    end else begin
                        rk_valid_d = 1'b0;
                        cnt_d      = LAT_C;
                    end
                end
            end
            ST_SUB: begin
                if (cnt_q == 2'd0) begin
                    rk_d       = nk;
                    w_d        = {w_q[128:255], nk};
                    idx_d      = idx_next;
                    rk_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            w_q        <= '0;
            rk_q       <= '0;
            idx_q      <= '0;
            rk_valid_q <= 1'b0;
            done_q     <= 1'b0;
            cnt_q      <= '0;
        end else begin
            w_q        <= w_d;
            rk_q       <= rk_d;
            idx_q      <= idx_d;
            rk_valid_q <= rk_valid_d;
            done_q     <= done_d;
            cnt_q      <= cnt_d;
        end
    end

    assign bus.RK_VALID = rk_valid_q;
    assign bus.RK       = rk_q;
    assign bus.RK_IDX   = idx_q;
    assign bus.DONE     = done_q;

endmodule

// File: tb/tb_aes256_key_sched_seq.sv
// Bench for the AES-256 key scheduler: two instances (S-box latency 1 and 3)
// checked against a FIPS-style word-expansion model with a GF(2^8) S-box.
module tb_aes256_key_sched_seq;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic         use3      = 1'b0;
    logic         key_valid = 1'b0;
    logic [255:0] key       = '0;
    logic         rk_ready  = 1'b0;

    aes256_key_sched_seq_if if1 ();
    aes256_key_sched_seq_if if3 ();

    aes256_key_sched_seq #(.SBOX_LAT(1)) dut_l1 (.CLK(clk), .RST_N(rst_n), .bus(if1.slave));
    aes256_key_sched_seq #(.SBOX_LAT(3)) dut_l3 (.CLK(clk), .RST_N(rst_n), .bus(if3.slave));

    assign if1.KEY_VALID = key_valid & ~use3;
    assign if3.KEY_VALID = key_valid & use3;
    assign if1.KEY       = key;
    assign if3.KEY       = key;
    assign if1.RK_READY  = rk_ready;
    assign if3.RK_READY  = rk_ready;

    logic         o_key_ready, o_rk_valid, o_busy, o_done;
    logic [127:0] o_rk;
    logic [3:0]   o_idx;
    assign o_key_ready = use3 ? if3.KEY_READY : if1.KEY_READY;
    assign o_rk_valid  = use3 ? if3.RK_VALID  : if1.RK_VALID;
    assign o_busy      = use3 ? if3.BUSY      : if1.BUSY;
    assign o_done      = use3 ? if3.DONE      : if1.DONE;
    assign o_rk        = use3 ? if3.RK        : if1.RK;
    assign o_idx       = use3 ? if3.RK_IDX    : if1.RK_IDX;

    int n_cmp  = 0;
    int n_mism = 0;

    localparam logic [255:0] FIPS_KEY =
        256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    // ---------------- reference model ----------------
    logic [7:0]   sbox_ref [256];
    logic [127:0] exp_rk   [15];

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        logic [15:0] d;
        d = {x, x} << n;
        return d[15:8];
    endfunction

    // S-box from its definition: multiplicative inverse then affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        for (int v = 0; v < 256; v++) begin
            inv = 8'h00;
            for (int c = 1; c < 256; c++)
                if (gmul(8'(v), 8'(c)) == 8'h01) inv = 8'(c);
            sbox_ref[v] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] sub_word_ref(input logic [31:0] t);
        return {sbox_ref[t[31:24]], sbox_ref[t[23:16]], sbox_ref[t[15:8]], sbox_ref[t[7:0]]};
    endfunction

    task automatic model_expand(input logic [255:0] k);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc;
        for (int i = 0; i < 8; i++) w[i] = k[255-32*i -: 32];
        rc = 8'h01;
        for (int i = 8; i < 60; i++) begin
            t = w[i-1];
            if (i % 8 == 0) begin
                t  = sub_word_ref({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = xtime(rc);
            end else if (i % 8 == 4) begin
                t = sub_word_ref(t);
            end
            w[i] = w[i-8] ^ t;
        end
        for (int r = 0; r < 15; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [255:0] rand_key();
        logic [255:0] k;
        k = '0;
        for (int i = 0; i < 8; i++) k = {k[223:0], 32'($urandom())};
        return k;
    endfunction

    // ---------------- job driver / collector ----------------
    logic [127:0] got_rk  [$];
    logic [3:0]   got_idx [$];
    int           gaps    [$];
    int           stall_viol, kready_viol, acc_cyc, done_cyc;

    // inject_mode: 0 none, 1 pulse 'other' while busy, 2 hold 'other' valid.
    task automatic run_job(input logic [255:0] k, input int ready_pct,
                           input int inject_mode, input logic [255:0] other);
        logic         prev_stall;
        logic [127:0] prev_rk;
        logic [3:0]   prev_idx;
        int           low_run, budget;
        got_rk.delete(); got_idx.delete(); gaps.delete();
        stall_viol = 0; kready_viol = 0; acc_cyc = -1; done_cyc = -1;
        budget = 0;
        while (!o_key_ready && budget < 200) begin @(negedge clk); budget++; end
        key = k;
        key_valid = 1'b1;
        @(negedge clk);
        acc_cyc = cyc;
        key_valid = 1'b0;
        prev_stall = 1'b0; prev_rk = '0; prev_idx = '0;
        low_run = 0; budget = 0;
        while (!o_done && budget < 1000) begin
            if (o_key_ready) kready_viol++;
            if (prev_stall && (!o_rk_valid || o_rk !== prev_rk || o_idx !== prev_idx)) stall_viol++;
            if (o_rk_valid) begin
                if (low_run > 0) gaps.push_back(low_run);
                low_run = 0;
            end else begin
                low_run++;
            end
            rk_ready   = ($urandom_range(99) < ready_pct);
            prev_stall = o_rk_valid && !rk_ready;
            prev_rk    = o_rk;
            prev_idx   = o_idx;
            if (o_rk_valid && rk_ready) begin
                got_rk.push_back(o_rk);
                got_idx.push_back(o_idx);
            end
            case (inject_mode)
                1:       begin key = other; key_valid = (cyc % 3 == 0); end
                2:       begin key = other; key_valid = 1'b1; end
                default: key_valid = 1'b0;
            endcase
            @(negedge clk);
            budget++;
        end
        if (o_done) done_cyc = cyc;
        if (inject_mode != 2) key_valid = 1'b0;
        rk_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({o_key_ready, o_rk_valid, o_busy, o_done} !== 4'b1000) begin
            n_mism++;
            $display("FAIL reset_flags: kr/v/busy/done got %b want 1000",
                     {o_key_ready, o_rk_valid, o_busy, o_done});
        end
        n_cmp++;
        if (o_rk !== 128'h0 || o_idx !== 4'd0) begin
            n_mism++;
            $display("FAIL reset_rk: got %h idx %0d want 0 idx 0", o_rk, o_idx);
        end
        @(negedge clk);
        rst_n = 1'b1;
        rk_ready = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (o_rk_valid !== 1'b0 || o_idx !== 4'd0 || o_busy !== 1'b0) begin
            n_mism++;
            $display("FAIL idle_ready_no_effect: valid %b idx %0d busy %b want 0 0 0",
                     o_rk_valid, o_idx, o_busy);
        end
        rk_ready = 1'b0;
    endtask

    task automatic test_fips_vector();
        int bad;
        use3 = 1'b0;
        model_expand(FIPS_KEY);
        run_job(FIPS_KEY, 100, 0, '0);
        n_cmp++;
        if (got_rk.size() != 15) begin
            n_mism++; $display("FAIL fips_count: got %0d keys want 15", got_rk.size());
        end
        for (int r = 0; r < 15 && r < got_rk.size(); r++) begin
            n_cmp++;
            if (got_rk[r] !== exp_rk[r] || got_idx[r] !== 4'(r)) begin
                n_mism++;
                $display("FAIL fips_rk: #%0d got %h/%0d want %h/%0d", r, got_rk[r], got_idx[r], exp_rk[r], r);
            end
        end
        if (got_rk.size() == 15) begin
            n_cmp++;
            if (got_rk[0] !== FIPS_KEY[255:128] || got_rk[1] !== FIPS_KEY[127:0]) begin
                n_mism++; $display("FAIL fips_rk01: got %h %h want key halves", got_rk[0], got_rk[1]);
            end
            n_cmp++;
            if (got_rk[2] !== 128'h9ba354118e6925afa51a8b5f2067fcde) begin
                n_mism++; $display("FAIL fips_rk2: got %h want 9ba354118e6925afa51a8b5f2067fcde", got_rk[2]);
            end
            n_cmp++;
            if (got_rk[3][127:96] !== 32'ha8b09c1a) begin
                n_mism++; $display("FAIL fips_rk3w0: got %h want a8b09c1a", got_rk[3][127:96]);
            end
            n_cmp++;
            if (got_rk[14] !== 128'hfe4890d1e6188d0b046df344706c631e) begin
                n_mism++; $display("FAIL fips_rk14: got %h want fe4890d1e6188d0b046df344706c631e", got_rk[14]);
            end
        end
        n_cmp++;
        if (done_cyc - acc_cyc != 41) begin
            n_mism++; $display("FAIL fips_job_time: got %0d cycles want 41", done_cyc - acc_cyc);
        end
        bad = 0;
        for (int i = 0; i < gaps.size(); i++) if (gaps[i] != 2) bad++;
        n_cmp++;
        if (gaps.size() != 13 || bad != 0) begin
            n_mism++; $display("FAIL fips_gaps: %0d gaps, %0d not 2 cycles; want 13 gaps of 2", gaps.size(), bad);
        end
        @(negedge clk);
        n_cmp++;
        if (o_done !== 1'b0 || o_busy !== 1'b0) begin
            n_mism++; $display("FAIL fips_done_pulse: done %b busy %b one cycle later, want 0 0", o_done, o_busy);
        end
    endtask

    task automatic test_backpressure();
        logic [255:0] k;
        int bad;
        use3 = 1'b0;
        for (int j = 0; j < 3; j++) begin
            k = (j == 0) ? FIPS_KEY : rand_key();
            model_expand(k);
            run_job(k, 55, 0, '0);
            n_cmp++;
            if (got_rk.size() != 15) begin
                n_mism++; $display("FAIL bp_count: job %0d got %0d keys want 15", j, got_rk.size());
            end
            for (int r = 0; r < 15 && r < got_rk.size(); r++) begin
                n_cmp++;
                if (got_rk[r] !== exp_rk[r] || got_idx[r] !== 4'(r)) begin
                    n_mism++;
                    $display("FAIL bp_rk: job %0d #%0d got %h/%0d want %h/%0d", j, r, got_rk[r], got_idx[r], exp_rk[r], r);
                end
            end
            n_cmp++;
            if (stall_viol != 0) begin
                n_mism++; $display("FAIL bp_stable: %0d changes while stalled, want 0", stall_viol);
            end
            bad = 0;
            for (int i = 0; i < gaps.size(); i++) if (gaps[i] != 2) bad++;
            n_cmp++;
            if (gaps.size() != 13 || bad != 0) begin
                n_mism++; $display("FAIL bp_gaps: %0d gaps, %0d not 2 cycles; want 13 gaps of 2", gaps.size(), bad);
            end
        end
    endtask

    task automatic test_busy_ignore();
        logic [255:0] ka, kb;
        use3 = 1'b0;
        ka = rand_key();
        kb = ~ka;
        model_expand(ka);
        run_job(ka, 80, 1, kb);
        n_cmp++;
        if (got_rk.size() != 15) begin
            n_mism++; $display("FAIL busy_count: got %0d keys want 15", got_rk.size());
        end
        for (int r = 0; r < 15 && r < got_rk.size(); r++) begin
            n_cmp++;
            if (got_rk[r] !== exp_rk[r] || got_idx[r] !== 4'(r)) begin
                n_mism++;
                $display("FAIL busy_rk: #%0d got %h/%0d want %h/%0d", r, got_rk[r], got_idx[r], exp_rk[r], r);
            end
        end
        n_cmp++;
        if (kready_viol != 0) begin
            n_mism++; $display("FAIL busy_key_ready: high on %0d busy cycles, want 0", kready_viol);
        end
    endtask

    task automatic test_mid_reset();
        logic [255:0] k;
        int budget, done_seen;
        use3 = 1'b0;
        k = rand_key();
        key = k;
        key_valid = 1'b1;
        @(negedge clk);
        key_valid = 1'b0;
        rk_ready = 1'b1;
        budget = 0;
        while (!(o_idx == 4'd6 && !o_rk_valid) && budget < 200) begin @(negedge clk); budget++; end
        n_cmp++;
        if (o_idx !== 4'd6 || o_rk_valid !== 1'b0 || o_busy !== 1'b1) begin
            n_mism++; $display("FAIL midrst_reach_sub: idx %0d valid %b busy %b want 6 0 1", o_idx, o_rk_valid, o_busy);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (o_rk_valid !== 1'b0 || o_busy !== 1'b0 || o_rk !== 128'h0 || o_idx !== 4'd0 || o_key_ready !== 1'b1) begin
            n_mism++;
            $display("FAIL midrst_async: valid %b busy %b rk %h idx %0d kr %b want 0 0 0 0 1",
                     o_rk_valid, o_busy, o_rk, o_idx, o_key_ready);
        end
        done_seen = 0;
        repeat (2) begin @(negedge clk); if (o_done) done_seen++; end
        rst_n = 1'b1;
        repeat (6) begin @(negedge clk); if (o_done || o_rk_valid) done_seen++; end
        rk_ready = 1'b0;
        n_cmp++;
        if (done_seen != 0) begin
            n_mism++; $display("FAIL midrst_no_done: done/valid seen %0d times, want 0", done_seen);
        end
        k = rand_key();
        model_expand(k);
        run_job(k, 70, 0, '0);
        n_cmp++;
        if (got_rk.size() != 15) begin
            n_mism++; $display("FAIL midrst_count: got %0d keys want 15", got_rk.size());
        end
        for (int r = 0; r < 15 && r < got_rk.size(); r++) begin
            n_cmp++;
            if (got_rk[r] !== exp_rk[r] || got_idx[r] !== 4'(r)) begin
                n_mism++;
                $display("FAIL midrst_rk: #%0d got %h/%0d want %h/%0d", r, got_rk[r], got_idx[r], exp_rk[r], r);
            end
        end
    endtask

    task automatic test_lat3();
        logic [255:0] k;
        int bad;
        use3 = 1'b1;
        for (int j = 0; j < 2; j++) begin
            k = (j == 0) ? 256'h0 : rand_key();
            model_expand(k);
            run_job(k, (j == 0) ? 100 : 60, 0, '0);
            n_cmp++;
            if (got_rk.size() != 15) begin
                n_mism++; $display("FAIL lat3_count: job %0d got %0d keys want 15", j, got_rk.size());
            end
            for (int r = 0; r < 15 && r < got_rk.size(); r++) begin
                n_cmp++;
                if (got_rk[r] !== exp_rk[r] || got_idx[r] !== 4'(r)) begin
                    n_mism++;
                    $display("FAIL lat3_rk: job %0d #%0d got %h/%0d want %h/%0d", j, r, got_rk[r], got_idx[r], exp_rk[r], r);
                end
            end
            bad = 0;
            for (int i = 0; i < gaps.size(); i++) if (gaps[i] != 4) bad++;
            n_cmp++;
            if (gaps.size() != 13 || bad != 0) begin
                n_mism++; $display("FAIL lat3_gaps: %0d gaps, %0d not 4 cycles; want 13 gaps of 4", gaps.size(), bad);
            end
            if (j == 0) begin
                n_cmp++;
                if (got_rk.size() < 3 || got_rk[2] !== 128'h62636363626363636263636362636363) begin
                    n_mism++; $display("FAIL lat3_zero_rk2: got %h want 62636363 x4", (got_rk.size() < 3) ? 128'hx : got_rk[2]);
                end
                n_cmp++;
                if (done_cyc - acc_cyc != 67) begin
                    n_mism++; $display("FAIL lat3_job_time: got %0d cycles want 67", done_cyc - acc_cyc);
                end
            end
        end
        use3 = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [255:0] ka, kb;
        int first_done;
        use3 = 1'b0;
        ka = rand_key();
        kb = rand_key();
        model_expand(ka);
        run_job(ka, 100, 2, kb);
        first_done = done_cyc;
        n_cmp++;
        if (kready_viol != 0 || o_key_ready !== 1'b1 || o_busy !== 1'b0) begin
            n_mism++;
            $display("FAIL b2b_first_ready: busy-cycle kr %0d, at done kr %b busy %b; want 0 1 0",
                     kready_viol, o_key_ready, o_busy);
        end
        for (int r = 0; r < 15; r++) begin
            n_cmp++;
            if (r >= got_rk.size() || got_rk[r] !== exp_rk[r]) begin
                n_mism++;
                $display("FAIL b2b_first_rk: #%0d got %h want %h", r, (r < got_rk.size()) ? got_rk[r] : 128'hx, exp_rk[r]);
            end
        end
        model_expand(kb);
        run_job(kb, 75, 0, '0);
        n_cmp++;
        if (acc_cyc != first_done + 1) begin
            n_mism++; $display("FAIL b2b_accept_cycle: accepted at %0d want %0d", acc_cyc, first_done + 1);
        end
        for (int r = 0; r < 15; r++) begin
            n_cmp++;
            if (r >= got_rk.size() || got_rk[r] !== exp_rk[r] || got_idx[r] !== 4'(r)) begin
                n_mism++;
                $display("FAIL b2b_second_rk: #%0d got %h want %h", r, (r < got_rk.size()) ? got_rk[r] : 128'hx, exp_rk[r]);
            end
        end
    endtask

    initial begin
        build_sbox();
        test_reset();
        test_fips_vector();
        test_backpressure();
        test_busy_ignore();
        test_mid_reset();
        test_lat3();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mism);
        $finish;
    end

endmodule
